// File: rtl/regtrace_difftest_queue.sv
`timescale 1ns/1ps
// regtrace_difftest_queue
//
// Purpose: buffers per-cycle commit trace records (PC, warp, thread mask and
// NUM_REG_PORTS register-write ports) in a DEPTH-entry FIFO. It then serialises
// the enabled write ports of the head record, one beat per cycle, onto a
// valid/ready stream for the simulator-side checker. A record that arrives
// while the FIFO is full is dropped and counted. A drain request is reported
// back through a sticky "finished" flag once the queue has emptied.
//
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   trace_valid/ready     commit record in; ready = FIFO not full
//   trace_pc/warpId/tmask record header
//   trace_regs_enable     per-port write enables
//   trace_regs_address    port p at [p*REG_BITS +: REG_BITS]
//   trace_regs_data       port p lane l at [(p*NUM_LANES+l)*ARCH_LEN +: ARCH_LEN]
//   out_valid/out_ready   beat stream handshake
//   out_pc/warpId/tmask   header of the head record
//   out_reg_enable        beat carries a register write (0 for no-write record)
//   out_port/address/data source port, address and lane data of the beat
//   out_last              final beat of the head record
//   drain_req, finished   end-of-simulation request / sticky completion
//   overflow, drop_count  sticky drop flag, saturating drop counter
module regtrace_difftest_queue #(
  parameter int ARCH_LEN      = 32,
  parameter int NUM_WARPS     = 8,
  parameter int NUM_LANES     = 16,
  parameter int REG_BITS      = 8,
  parameter int NUM_REG_PORTS = 3,
  parameter int DEPTH         = 16,
  parameter int CNT_BITS      = 16,
  parameter int WARP_ID_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int PORT_BITS     = (NUM_REG_PORTS > 1) ? $clog2(NUM_REG_PORTS) : 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      trace_valid,
  output logic                                      trace_ready,
  input  logic [ARCH_LEN-1:0]                       trace_pc,
  input  logic [WARP_ID_BITS-1:0]                   trace_warpId,
  input  logic [NUM_LANES-1:0]                      trace_tmask,
  input  logic [NUM_REG_PORTS-1:0]                  trace_regs_enable,
  input  logic [NUM_REG_PORTS*REG_BITS-1:0]         trace_regs_address,
  input  logic [NUM_REG_PORTS*NUM_LANES*ARCH_LEN-1:0] trace_regs_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ARCH_LEN-1:0]                       out_pc,
  output logic [WARP_ID_BITS-1:0]                   out_warpId,
  output logic [NUM_LANES-1:0]                      out_tmask,
  output logic                                      out_reg_enable,
  output logic [PORT_BITS-1:0]                      out_port,
  output logic [REG_BITS-1:0]                       out_address,
  output logic [NUM_LANES*ARCH_LEN-1:0]             out_data,
  output logic                                      out_last,
  input  logic                                      drain_req,
  output logic                                      finished,
  output logic                                      overflow,
  output logic [CNT_BITS-1:0]                       drop_count
);

  localparam int PTR_BITS  = $clog2(DEPTH);
  localparam int LANE_W    = NUM_LANES * ARCH_LEN;
  localparam int DATA_W    = NUM_REG_PORTS * LANE_W;
  localparam int ADDR_W    = NUM_REG_PORTS * REG_BITS;

  // Record storage; contents need no reset because r_count gates every read.
  logic [ARCH_LEN-1:0]      r_pc    [DEPTH];
  logic [WARP_ID_BITS-1:0]  r_warp  [DEPTH];
  logic [NUM_LANES-1:0]     r_tmask [DEPTH];
  logic [NUM_REG_PORTS-1:0] r_en    [DEPTH];
  logic [ADDR_W-1:0]        r_addr  [DEPTH];
  logic [DATA_W-1:0]        r_data  [DEPTH];

  logic [PTR_BITS-1:0]      r_wr_ptr;
  logic [PTR_BITS-1:0]      r_rd_ptr;
  logic [PTR_BITS:0]        r_count;
  logic [NUM_REG_PORTS-1:0] r_rem_mask;
  logic                     r_ready;
  logic                     r_overflow;
  logic [CNT_BITS-1:0]      r_drop_count;
  logic                     r_drain_pending;
  logic                     r_finished;

  logic                     w_valid;
  logic                     w_full;
  logic                     w_push;
  logic                     w_fire;
  logic                     w_last;
  logic                     w_pop;
  logic [PTR_BITS:0]        w_count_nxt;
  logic [PTR_BITS-1:0]      w_rd_nxt;
  logic [NUM_REG_PORTS-1:0] w_low;
  logic [PORT_BITS-1:0]     w_sel;
  logic [REG_BITS-1:0]      w_addr;
  logic [LANE_W-1:0]        w_data;

  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == (PTR_BITS+1)'(DEPTH));
  // Acceptance looks only at the registered count: a pop this cycle does not
  // free a slot for a same-cycle enqueue.
  assign w_push   = trace_valid && !w_full;
  // A no-write record (empty mask) is a single terminal beat.
  assign w_last   = (r_rem_mask == '0) || $onehot(r_rem_mask);
  assign w_fire   = w_valid && out_ready;
  assign w_pop    = w_fire && w_last;
  assign w_rd_nxt = r_rd_ptr + PTR_BITS'(1);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PTR_BITS+1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_BITS+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Lowest pending port: isolate the least significant set bit, then mux
  // address and lane data from that port of the head entry.
  always_comb begin
    w_low  = r_rem_mask & (~r_rem_mask + NUM_REG_PORTS'(1));
    w_sel  = '0;
    w_addr = '0;
    w_data = '0;
    for (int p = 0; p < NUM_REG_PORTS; p++) begin
      if (w_low[p]) begin
        w_sel  = PORT_BITS'(p);
        w_addr = r_addr[r_rd_ptr][p*REG_BITS +: REG_BITS];
        w_data = r_data[r_rd_ptr][p*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= trace_pc;
      r_warp[r_wr_ptr]  <= trace_warpId;
      r_tmask[r_wr_ptr] <= trace_tmask;
      r_en[r_wr_ptr]    <= trace_regs_enable;
      r_addr[r_wr_ptr]  <= trace_regs_address;
      r_data[r_wr_ptr]  <= trace_regs_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_rem_mask      <= '0;
      r_ready         <= 1'b0;
      r_overflow      <= 1'b0;
      r_drop_count    <= '0;
      r_drain_pending <= 1'b0;
      r_finished      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != (PTR_BITS+1)'(DEPTH));

      // The mask always mirrors whichever record will be at the head after
      // this edge: the next stored entry, the record being written right now
      // (when it lands in an otherwise empty queue), or nothing.
      if (w_pop) begin
        if (r_count > (PTR_BITS+1)'(1)) r_rem_mask <= r_en[w_rd_nxt];
        else if (w_push)                r_rem_mask <= trace_regs_enable;
        else                            r_rem_mask <= '0;
      end else if (w_fire) begin
        r_rem_mask <= r_rem_mask & ~w_low;
      end else if (!w_valid && w_push) begin
        r_rem_mask <= trace_regs_enable;
      end

      if (trace_valid && w_full) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_BITS'(1);
      end

      if (r_drain_pending && !w_valid && !trace_valid) r_finished <= 1'b1;
      if (drain_req) r_drain_pending <= 1'b1;
    end
  end

  assign trace_ready    = r_ready;
  assign out_valid      = w_valid;
  assign out_pc         = w_valid ? r_pc[r_rd_ptr]    : '0;
  assign out_warpId     = w_valid ? r_warp[r_rd_ptr]  : '0;
  assign out_tmask      = w_valid ? r_tmask[r_rd_ptr] : '0;
  assign out_reg_enable = w_valid && (r_rem_mask != '0);
  assign out_port       = w_valid ? w_sel  : '0;
  assign out_address    = w_valid ? w_addr : '0;
  assign out_data       = w_valid ? w_data : '0;
  assign out_last       = w_valid && w_last;
  assign finished       = r_finished;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop_count;

endmodule

// File: tb/tb_regtrace_difftest_queue.sv
`timescale 1ns/1ps
// Testbench for regtrace_difftest_queue (DEPTH reduced to 4).
// A negedge monitor keeps a behavioural model (record occupancy, expected
// beat queue, drop/drain state), compares DUT outputs every cycle and pops
// expected beats as the stream fires.
module tb_regtrace_difftest_queue;

  localparam int AL = 32, NW = 8, WB = 3, NL = 16, RB = 8, NRP = 3, PB = 2;
  localparam int DEPTH = 4, CB = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 trace_valid;
  logic                 trace_ready;
  logic [AL-1:0]        trace_pc;
  logic [WB-1:0]        trace_warpId;
  logic [NL-1:0]        trace_tmask;
  logic [NRP-1:0]       trace_regs_enable;
  logic [NRP*RB-1:0]    trace_regs_address;
  logic [NRP*NL*AL-1:0] trace_regs_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AL-1:0]        out_pc;
  logic [WB-1:0]        out_warpId;
  logic [NL-1:0]        out_tmask;
  logic                 out_reg_enable;
  logic [PB-1:0]        out_port;
  logic [RB-1:0]        out_address;
  logic [NL*AL-1:0]     out_data;
  logic                 out_last;
  logic                 drain_req;
  logic                 finished;
  logic                 overflow;
  logic [CB-1:0]        drop_count;

  regtrace_difftest_queue #(
    .ARCH_LEN(AL), .NUM_WARPS(NW), .NUM_LANES(NL), .REG_BITS(RB),
    .NUM_REG_PORTS(NRP), .DEPTH(DEPTH), .CNT_BITS(CB)
  ) dut (
    .clock(clock), .reset(reset),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_warpId(trace_warpId), .trace_tmask(trace_tmask),
    .trace_regs_enable(trace_regs_enable), .trace_regs_address(trace_regs_address),
    .trace_regs_data(trace_regs_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_warpId(out_warpId), .out_tmask(out_tmask), .out_reg_enable(out_reg_enable),
    .out_port(out_port), .out_address(out_address), .out_data(out_data),
    .out_last(out_last), .drain_req(drain_req), .finished(finished),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AL-1:0]    pc;
    logic [WB-1:0]    warp;
    logic [NL-1:0]    tmask;
    logic             en;
    logic [PB-1:0]    port;
    logic [RB-1:0]    addr;
    logic [NL*AL-1:0] data;
    logic             last;
  } beat_t;

  beat_t      sb[$];
  int         occ = 0;
  logic       m_ready = 1'b0, m_ovf = 1'b0, m_fin = 1'b0, m_drain = 1'b0;
  logic [CB-1:0] m_drop = '0;
  logic       mon_en = 1'b0;
  int         n_cmp = 0, n_mis = 0;

  task automatic chk(input string nm, input logic [NL*AL-1:0] got, input logic [NL*AL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("trace_ready", trace_ready, m_ready);
      chk("out_valid", out_valid, occ != 0);
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drop);
      chk("finished", finished, m_fin);
      if (sb.size() > 0) begin
        chk("out_pc", out_pc, sb[0].pc);
        chk("out_warpId", out_warpId, sb[0].warp);
        chk("out_tmask", out_tmask, sb[0].tmask);
        chk("out_reg_enable", out_reg_enable, sb[0].en);
        chk("out_port", out_port, sb[0].port);
        chk("out_address", out_address, sb[0].addr);
        chk("out_data", out_data, sb[0].data);
        chk("out_last", out_last, sb[0].last);
      end
      if (reset) begin
        sb.delete();
        occ = 0; m_ready = 1'b0; m_ovf = 1'b0; m_fin = 1'b0; m_drain = 1'b0; m_drop = '0;
      end else begin
        logic accept;
        accept = trace_valid && (occ < DEPTH);
        if (trace_valid && !accept) begin
          m_ovf = 1'b1;
          if (m_drop != '1) m_drop = m_drop + 1'b1;
        end
        if (m_drain && occ == 0 && !trace_valid) m_fin = 1'b1;
        if (drain_req) m_drain = 1'b1;
        if (sb.size() > 0 && out_ready) begin
          if (sb[0].last) occ--;
          void'(sb.pop_front());
        end
        if (accept) begin
          int nen, k;
          beat_t b;
          nen = $countones(trace_regs_enable);
          k = 0;
          b.pc = trace_pc; b.warp = trace_warpId; b.tmask = trace_tmask;
          if (nen == 0) begin
            b.en = 1'b0; b.port = '0; b.addr = '0; b.data = '0; b.last = 1'b1;
            sb.push_back(b);
          end else begin
            for (int p = 0; p < NRP; p++) begin
              if (trace_regs_enable[p]) begin
                k++;
                b.en = 1'b1; b.port = PB'(p);
                b.addr = trace_regs_address[p*RB +: RB];
                b.data = trace_regs_data[p*NL*AL +: NL*AL];
                b.last = (k == nen);
                sb.push_back(b);
              end
            end
          end
          occ++;
        end
        m_ready = (occ < DEPTH);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input logic [AL-1:0] pc, input logic [WB-1:0] warp,
                      input logic [NRP-1:0] en, input logic [NRP*RB-1:0] addrs);
    trace_valid        = 1'b1;
    trace_pc           = pc;
    trace_warpId       = warp;
    trace_tmask        = NL'($urandom);
    trace_regs_enable  = en;
    trace_regs_address = addrs;
    for (int w = 0; w < NRP*NL; w++) trace_regs_data[w*AL +: AL] = $urandom;
  endtask

  task automatic send(input logic [AL-1:0] pc, input logic [WB-1:0] warp,
                      input logic [NRP-1:0] en, input logic [NRP*RB-1:0] addrs);
    load(pc, warp, en, addrs);
    step(1);
    trace_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int c;
    c = 0;
    while (occ != 0 && c < budget) begin
      step(1);
      c++;
    end
    if (occ != 0) begin
      n_mis++;
      $display("FAIL %s: timeout, %0d records still queued, required 0", nm, occ);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [NRP*RB-1:0] ra;
    reset = 1'b1; trace_valid = 1'b0; out_ready = 1'b0; drain_req = 1'b0;
    trace_pc = '0; trace_warpId = '0; trace_tmask = '0; trace_regs_enable = '0;
    trace_regs_address = '0; trace_regs_data = '0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);

    // Two-beat record: port 0 then port 2.
    out_ready = 1'b1;
    send(32'h8000_0000, 3'd3, 3'b101, {8'd9, 8'd0, 8'd5});
    step(4);

    // No-write record: a single terminal beat.
    send(32'h0000_0100, 3'd1, 3'b000, 24'h0);
    step(3);

    // Overflow: six single-enable records into a stalled queue of four.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra = NRP*RB'($urandom);
      send(32'h1000 + 32'(i), WB'(i), NRP'(1 << (i % NRP)), ra);
    end
    step(3);
    out_ready = 1'b1;
    wait_empty("overflow_drain", 40);
    step(2);

    // Stall pattern with three-beat records, flow-controlled on trace_ready.
    fork
      begin
        for (int c = 0; c < 120; c++) begin
          out_ready = (c % 2 == 0);
          step(1);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          int g;
          g = 0;
          while (!trace_ready && g < 50) begin
            step(1);
            g++;
          end
          ra = NRP*RB'($urandom);
          send(32'h2000 + 32'(i * 4), WB'(i), 3'b111, ra);
        end
      end
    join
    wait_empty("stall_stream", 60);
    step(2);

    // Drain handshake with three queued records, then a late record.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = NRP*RB'($urandom);
      send(32'h3000 + 32'(i), WB'(i), NRP'($urandom_range(0, 7)), ra);
    end
    drain_req = 1'b1;
    step(1);
    drain_req = 1'b0;
    out_ready = 1'b1;
    wait_empty("drain", 30);
    step(3);
    send(32'h3100, 3'd5, 3'b110, 24'h0a0b0c);
    wait_empty("post_finish", 10);
    step(2);

    // Reset in the middle of a three-beat record.
    out_ready = 1'b0;
    send(32'h4000, 3'd2, 3'b111, 24'h030201);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    out_ready = 1'b1;
    send(32'h4100, 3'd6, 3'b011, 24'h112233);
    wait_empty("after_reset", 10);
    step(2);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drain_req = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ra = NRP*RB'($urandom);
        load($urandom, WB'($urandom), NRP'($urandom), ra);
      end else begin
        trace_valid = 1'b0;
      end
      step(1);
    end
    trace_valid = 1'b0;
    drain_req = 1'b0;
    out_ready = 1'b1;
    wait_empty("random_drain", 40);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/regtrace_difftest_queue.md
Name: regtrace_difftest_queue

Overview:
- Parametrised successor to the per-cycle register-trace difftest hookup.
- Captures commit trace records with a configurable number of register write ports and a thread mask into a DEPTH-entry FIFO.
- Serialises the enabled write ports, one beat per cycle, onto a valid/ready stream consumed by the simulator-side checker.
- Handles backpressure, drop accounting and a drain/finish handshake, so the checker need not keep pace with commit.

Parameters:
ARCH_LEN, 32, data width per lane and PC width
NUM_WARPS, 8, warp count; WARP_ID_BITS = max(1, clog2(NUM_WARPS))
NUM_LANES, 16, lanes per warp
REG_BITS, 8, register address width
NUM_REG_PORTS, 3, write ports per trace record (>=1); PORT_BITS = max(1, clog2(NUM_REG_PORTS))
DEPTH, 16, FIFO entries, power of two, >=2
CNT_BITS, 16, width of drop counter

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
trace_valid  in  1  commit record present this cycle
trace_ready  out  1  FIFO not full
trace_pc  in  ARCH_LEN  record PC
trace_warpId  in  WARP_ID_BITS  record warp
trace_tmask  in  NUM_LANES  active-lane mask
trace_regs_enable  in  NUM_REG_PORTS  per-port write enable
trace_regs_address  in  NUM_REG_PORTS*REG_BITS  port p at [p*REG_BITS +: REG_BITS]
trace_regs_data  in  NUM_REG_PORTS*NUM_LANES*ARCH_LEN  port p lane l at [(p*NUM_LANES+l)*ARCH_LEN +: ARCH_LEN]
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_pc  out  ARCH_LEN  head record PC
out_warpId  out  WARP_ID_BITS  head record warp
out_tmask  out  NUM_LANES  head record mask
out_reg_enable  out  1  beat carries a register write
out_port  out  PORT_BITS  source port index of beat
out_address  out  REG_BITS  register address of beat
out_data  out  NUM_LANES*ARCH_LEN  lane data of beat; lane l at [l*ARCH_LEN +: ARCH_LEN]
out_last  out  1  final beat of the record
drain_req  in  1  end of simulation requested (pulse or level)
finished  out  1  drain complete, sticky
overflow  out  1  sticky: at least one record dropped
drop_count  out  CNT_BITS  records dropped, saturating

Behaviour:
Reset values:
- All outputs 0 during and after reset, except trace_ready = 1 the cycle after reset deasserts.
- Reset in any cycle empties the FIFO, clears the serialiser mask, finished, overflow, drop_count and the latched drain request. Any in-flight beat is discarded.

Enqueue:
- trace_ready = !full, with no same-cycle bypass from dequeue.
- trace_valid && !full: the whole record (pc, warpId, tmask, enables, addresses, data) is written at the tail.
- trace_valid && full: the record is dropped; overflow <= 1; drop_count increments, saturating at all-ones.
- Records with all enables clear are still enqueued.

Latency:
- Record enqueued at edge t is visible on out_* from cycle t+1.
- No combinational path from trace_* to out_*.

Serialiser:
- rem_mask (NUM_REG_PORTS bits) is loaded with the head entry's enables whenever a new head becomes valid.
- Selected port sel = lowest set bit of rem_mask.
- out_valid = !empty.
- rem_mask != 0: out_reg_enable = 1; out_port = sel; out_address and out_data come from port sel; out_last = (rem_mask has exactly one bit set).
- rem_mask == 0 (no-write record): a single beat with out_reg_enable = 0, out_port = 0, out_address = 0, out_data = 0, out_last = 1.
- Fire = out_valid && out_ready.
  - Fire && !out_last: clear bit sel.
  - Fire && out_last: pop head; rem_mask reloads from the next head on the same edge if one exists.
- out_* are stable while out_valid && !out_ready.
- Simultaneous enqueue and pop are both performed; occupancy is unchanged.
- Pointers wrap modulo DEPTH; full/empty are tracked by a count register (0..DEPTH).

Drain:
- drain_req high in any cycle latches drain_pending.
- finished <= 1 at the first edge where drain_pending is set, the FIFO is empty and no trace_valid is present that cycle.
- finished stays 1 until reset.
- Records arriving after finished are still queued and emitted; finished does not drop.

Test Plan:
- One record: pc=0x8000_0000, warp 3, enables=3'b101, addr0=5, addr2=9 -> two beats: out_port=0/addr 5/out_last=0, then out_port=2/addr 9/out_last=1; first out_valid one cycle after enqueue.
- Record with enables=0, pc=0x100 -> exactly one beat: out_reg_enable=0, out_last=1, out_pc=0x100.
- DEPTH=4, out_ready=0, 6 consecutive records (one enable each) -> trace_ready=0 after the 4th, drop_count=2, overflow=1; after releasing out_ready, exactly 4 records emitted in order.
- out_ready toggled 1,0,1 every cycle, streaming 10 records with enables=3'b111 -> 30 beats in order, out_* held stable across stalls, no loss.
- drain_req pulse with 3 records queued, out_ready=1 -> finished rises only after the last out_last fire, then stays 1 while a later record is still emitted.
- Reset asserted mid-record (after the first of 3 beats) -> out_valid=0, drop_count=0, finished=0 next cycle; a new record after reset emits from port 0.
